mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the CPU instruction-fetch port and the load/store port.
//  Sits between the CPU core and the memory. Grants one access at a time and tracks fixed memory latency.
//  Routes read data or write acknowledge back to the owning requester.
// PARAMETERS
//  ADDR_W   32  address width, byte address, passed through unchecked
//  DATA_W   32  data width; strobe width is DATA_W/8
//  MEM_LAT  1   cycles from mem_en to valid mem_rdata; legal range 1..15
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         asynchronous, active-high reset
//  if_req     in   1         fetch request; held high until if_gnt
//  if_addr    in   ADDR_W    fetch address
//  if_gnt     out  1         fetch accepted this cycle
//  if_rvalid  out  1         1-cycle pulse: if_rdata valid
//  if_rdata   out  DATA_W    fetched instruction word
//  d_req      in   1         load/store request; held high until d_gnt
//  d_we       in   1         1 = store, 0 = load
//  d_addr     in   ADDR_W    data address
//  d_wdata    in   DATA_W    store data
//  d_wstrb    in   DATA_W/8  store byte enables; ignored on load
//  d_gnt      out  1         data access accepted this cycle
//  d_rvalid   out  1         1-cycle pulse: load data valid, or store complete
//  d_rdata    out  DATA_W    load data; 0 on store completion
//  mem_en     out  1         memory access strobe, 1 cycle per access
//  mem_we     out  1         memory write enable
//  mem_addr   out  ADDR_W    memory address
//  mem_wdata  out  DATA_W    memory write data
//  mem_wstrb  out  DATA_W/8  memory byte enables; 0 on reads
//  mem_rdata  in   DATA_W    memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, owner NONE, latency counter 0. The rdata output registers clear to 0.
//  - FSM IDLE: if any request is pending, grant one request combinationally (gnt=1, mem_en=1, mem_* driven from the winner).
//    Latch owner and we, load cnt=MEM_LAT, go to BUSY. With no request, mem_en=0 and mem_* are 0.
//  - FSM BUSY: decrement cnt each cycle. No grant while cnt>1. In the cycle cnt==1:
//    - Capture mem_rdata into the owner's rdata register.
//    - Pulse the owner's rvalid on the next cycle (registered output).
//    - Return to IDLE, or regrant directly when a request is pending.
//    Throughput is one access per MEM_LAT cycles; latency is gnt-to-rvalid = MEM_LAT+1 cycles.
//  - Priority when both request: d_req wins; a stalled load/store blocks the pipeline. See ARB_RR_EN.
//  - Only one access is outstanding. if_gnt and d_gnt are never high together.
//  - Store completion: d_rvalid pulses with d_rdata=0. The rdata registers hold their value between pulses.
//  - A request that drops before its gnt is a protocol violation. It is flagged only by an assertion (non-synth).
//  - Reset mid-access: the outstanding access is abandoned and no rvalid is issued. Requesters reissue after reset.
//  - cnt width is 4 bits; MEM_LAT outside 1..15 triggers an elaboration error.
// CONFIGURATION
//  ARB_RR_EN defined:
//    - On a conflict, grant the port not granted last (1-bit last_owner register, reset = IF, so data wins first).
//    - Uncontended grants do not change the rotation order.
//  ARB_RR_EN undefined:
//    - Fixed data-over-fetch priority; no last_owner register.
// STRUCTURE
//  Shared package cpu_mem_pkg:
//    - Owner encoding OWN_NONE=2'd0, OWN_IF=2'd1, OWN_D=2'd2.
//    - ADDR_W/DATA_W defaults and the MEM_LAT_MAX=15 constant.
//  Single module, no sub-module. The FSM, counter and owner register are small enough for one file.
// TESTING
//  1 Fetch only: if_req, addr 0x10, MEM_LAT=1.
//    -> if_gnt at cycle 0, mem_en/mem_addr=0x10 at cycle 0.
//    -> if_rvalid at cycle 2 with the memory word.
//  2 Conflict: if_req and d_req (load, addr 0x200) both rise at cycle 0.
//    -> d_gnt at cycle 0, if_gnt at cycle MEM_LAT.
//    -> With ARB_RR_EN, a second conflict grants IF first.
//  3 Store: d_we=1, d_wstrb=4'b0011, data 0xDEADBEEF.
//    -> mem_we=1, mem_wstrb=0011 for one cycle; d_rvalid pulses with d_rdata=0.
//    -> A readback load returns 0x0000BEEF when memory was 0.
//  4 Back-to-back: MEM_LAT=3, 4 queued fetches.
//    -> Grants at cycles 0, 3, 6, 9; if_rvalid at cycles 4, 7, 10, 13.
//    -> Never two mem_en within 3 cycles.
//  5 Reset mid-access: assert reset 1 cycle after d_gnt with MEM_LAT=3.
//    -> No d_rvalid, all outputs 0 immediately (async).
//    -> A fresh request after deassertion is granted normally.
//  6 Starvation check, fixed priority: hold d_req high for 10 accesses.
//    -> if_gnt stays 0 throughout; with ARB_RR_EN, if_gnt occurs within every 2 grants.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-port arbiter: owner encoding,
// FSM states, default bus widths and latency counter sizing.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned MEM_LAT_MAX = 15;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch port and the
// load/store port. One access outstanding, fixed memory latency MEM_LAT.
// Optional round-robin conflict resolution when ARB_RR_EN is defined;
// otherwise data always wins over fetch.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  // Reject latencies the 4-bit counter cannot represent
  if (MEM_LAT == 0 || MEM_LAT > MEM_LAT_MAX) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be within 1..15");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  owner_t           owner_q;
  logic             we_q;

  logic last_c;
  logic slot_c;
  logic d_wins_c;
  logic grant_d_c;
  logic grant_if_c;
  logic grant_any_c;

`ifdef ARB_RR_EN
  logic last_if_q;

  // Remember who won the last contended grant; reset favours data first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_if_q <= 1'b1;
    end else if (slot_c && if_req && d_req) begin
      last_if_q <= grant_if_c;
    end
  end
`endif

  // Arbitration: a grant slot opens in IDLE or on the final busy cycle
  always_comb begin
    last_c = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));
    slot_c = !reset && ((state_q == ST_IDLE) || last_c);
`ifdef ARB_RR_EN
    d_wins_c = d_req && (!if_req || last_if_q);
`else
    d_wins_c = d_req;
`endif
    grant_d_c   = slot_c && d_wins_c;
    grant_if_c  = slot_c && if_req && !d_wins_c;
    grant_any_c = grant_d_c || grant_if_c;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stay busy across a direct regrant
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_any_c) state_d = ST_BUSY;
      ST_BUSY: if (last_c)      state_d = grant_any_c ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: grants and memory strobe driven from the winner, else 0
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (grant_d_c) begin
      d_gnt     = 1'b1;
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_we ? d_wdata : '0;
      mem_wstrb = d_we ? d_wstrb : STRB_W'(0);
    end else if (grant_if_c) begin
      if_gnt    = 1'b1;
      mem_en    = 1'b1;
      mem_addr  = if_addr;
    end
  end

  // Latency counter, owner tracking and read-data return to the owner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      owner_q   <= OWN_NONE;
      we_q      <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (last_c) begin
        if (owner_q == OWN_IF) begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end else if (owner_q == OWN_D) begin
          d_rvalid <= 1'b1;
          d_rdata  <= we_q ? '0 : mem_rdata;
        end
      end
      if (grant_any_c) begin
        cnt_q   <= CNT_W'(MEM_LAT);
        owner_q <= grant_d_c ? OWN_D : OWN_IF;
        we_q    <= grant_d_c && d_we;
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (last_c) begin
          owner_q <= OWN_NONE;
          we_q    <= 1'b0;
        end
      end
    end
  end

`ifndef SYNTHESIS
  // Requesters must hold their request until granted
  a_if_hold: assert property (@(posedge clk) disable iff (reset)
    (if_req && !if_gnt) |=> if_req)
    else $error("if_req dropped before if_gnt");

  a_d_hold: assert property (@(posedge clk) disable iff (reset)
    (d_req && !d_gnt) |=> d_req)
    else $error("d_req dropped before d_gnt");

  a_one_gnt: assert property (@(posedge clk) !(if_gnt && d_gnt))
    else $error("if_gnt and d_gnt asserted together");
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with MEM_LAT=3. Follows ARB_RR_EN.
module tb_mem_port_arbiter;

  localparam int LAT = 3;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F5A;
  endfunction

  // ---------------- memory environment (data valid LAT cycles after mem_en)
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] rd_now;
  logic [31:0] pipe [LAT];
  assign mem_rdata = pipe[LAT-1];

  always @(negedge clk) begin : env_access
    logic [31:0] w;
    rd_now = $urandom;
    if (mem_en) begin
      w = env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_word(mem_addr);
      if (mem_we) begin
        for (int b = 0; b < 4; b++) if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        env_mem[mem_addr] = w;
      end else begin
        rd_now = w;
      end
    end
  end

  always @(posedge clk) begin
    pipe[0] <= rd_now;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end

  // ---------------- reference model
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          gap;
  } txn_t;

  typedef struct {
    int          cyc;
    bit          is_d;
    logic [31:0] data;
  } ev_t;

  logic [31:0] ref_mem [logic [31:0]];
  txn_t if_q[$], d_q[$];
  ev_t  ev_q[$];
  txn_t if_p, d_p;
  bit   if_pv, d_pv;
  int   cyc, next_free;
  bit   rr_last_if;
  logic [31:0] exp_if_rdata, exp_d_rdata;
  int   n_chk, n_fail;
  bit   burst_mode, b2b_mode;
  int   obs_if_g_burst, streak, max_streak;
  int   gcyc[$];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pf(input logic [31:0] a, input int gap);
    txn_t t;
    t.we = 1'b0; t.addr = a; t.wdata = '0; t.wstrb = '0; t.gap = gap;
    if_q.push_back(t);
  endtask

  task automatic pd(input bit we, input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] ws, input int gap);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = wd; t.wstrb = ws; t.gap = gap;
    d_q.push_back(t);
  endtask

  function automatic bit busy();
    return (if_q.size() > 0) || (d_q.size() > 0) || if_pv || d_pv || (ev_q.size() > 0);
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge
  task automatic step();
    bit eg_if, eg_d, ev_if, ev_d;
    logic [31:0] w, dat;
    ev_t e;
    @(posedge clk); #1; cyc++;
    if (!if_pv && if_q.size() > 0) begin
      if (if_q[0].gap > 0) if_q[0].gap = if_q[0].gap - 1;
      else begin if_p = if_q.pop_front(); if_pv = 1'b1; end
    end
    if (!d_pv && d_q.size() > 0) begin
      if (d_q[0].gap > 0) d_q[0].gap = d_q[0].gap - 1;
      else begin d_p = d_q.pop_front(); d_pv = 1'b1; end
    end
    if_req  = if_pv;
    if_addr = if_pv ? if_p.addr : $urandom;
    d_req   = d_pv;
    d_we    = d_pv ? d_p.we : 1'($urandom);
    d_addr  = d_pv ? d_p.addr : $urandom;
    d_wdata = d_pv ? d_p.wdata : $urandom;
    d_wstrb = d_pv ? d_p.wstrb : 4'($urandom);
    @(negedge clk);

    eg_if = 1'b0; eg_d = 1'b0;
    if (cyc >= next_free) begin
      if (d_pv && (!if_pv || !RR || rr_last_if)) eg_d = 1'b1;
      else if (if_pv) eg_if = 1'b1;
      if (d_pv && if_pv) rr_last_if = eg_if;
    end
    chk("if_gnt", 64'(if_gnt), 64'(eg_if));
    chk("d_gnt", 64'(d_gnt), 64'(eg_d));
    chk("mem_en", 64'(mem_en), 64'(eg_if | eg_d));

    if (burst_mode && if_gnt && (d_pv || d_q.size() > 0)) obs_if_g_burst++;
    if (d_gnt) streak = if_req ? streak + 1 : 0;
    if (if_gnt) streak = 0;
    if (streak > max_streak) max_streak = streak;
    if (b2b_mode && if_gnt) gcyc.push_back(cyc);

    if (eg_d) begin
      chk("mem_we_d", 64'(mem_we), 64'(d_p.we));
      chk("mem_addr_d", 64'(mem_addr), 64'(d_p.addr));
      chk("mem_wstrb_d", 64'(mem_wstrb), d_p.we ? 64'(d_p.wstrb) : 64'(0));
      if (d_p.we) begin
        chk("mem_wdata_d", 64'(mem_wdata), 64'(d_p.wdata));
        w = ref_rd(d_p.addr);
        for (int b = 0; b < 4; b++) if (d_p.wstrb[b]) w[8*b +: 8] = d_p.wdata[8*b +: 8];
        ref_mem[d_p.addr] = w;
        dat = '0;
      end else begin
        dat = ref_rd(d_p.addr);
      end
      e.cyc = cyc + LAT + 1; e.is_d = 1'b1; e.data = dat;
      ev_q.push_back(e);
      next_free = cyc + LAT;
      d_pv = 1'b0;
    end else if (eg_if) begin
      chk("mem_we_if", 64'(mem_we), 64'(0));
      chk("mem_addr_if", 64'(mem_addr), 64'(if_p.addr));
      chk("mem_wstrb_if", 64'(mem_wstrb), 64'(0));
      e.cyc = cyc + LAT + 1; e.is_d = 1'b0; e.data = ref_rd(if_p.addr);
      ev_q.push_back(e);
      next_free = cyc + LAT;
      if_pv = 1'b0;
    end else if (!if_pv && !d_pv) begin
      chk("idle_mem_ctl", {59'd0, mem_we, mem_wstrb}, 64'(0));
      chk("idle_mem_bus", {mem_addr, mem_wdata}, 64'(0));
    end

    ev_if = 1'b0; ev_d = 1'b0;
    while (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
      e = ev_q.pop_front();
      if (e.is_d) begin ev_d = 1'b1; exp_d_rdata = e.data; end
      else begin ev_if = 1'b1; exp_if_rdata = e.data; end
    end
    chk("if_rvalid", 64'(if_rvalid), 64'(ev_if));
    chk("d_rvalid", 64'(d_rvalid), 64'(ev_d));
    chk("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
    chk("d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (busy() && n < max) begin step(); n++; end
    chk("drain_done", 64'(!busy()), 64'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {58'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we}, 64'(0));
    chk({tag, "_rdata"}, {if_rdata, d_rdata}, 64'(0));
    chk({tag, "_bus"}, {mem_addr, mem_wdata}, 64'(0));
    chk({tag, "_wstrb"}, 64'(mem_wstrb), 64'(0));
  endtask

  // Called at posedge+1: asserts reset, holds it, releases it
  task automatic do_reset(input int hold);
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
    if_pv = 1'b0; d_pv = 1'b0;
    ev_q.delete(); next_free = 0; rr_last_if = 1'b1;
    exp_if_rdata = '0; exp_d_rdata = '0;
    #1;
    chk_all_zero("rst_async");
    repeat (hold) begin
      @(posedge clk); #1; cyc++;
      @(negedge clk);
      chk_all_zero("rst_hold");
    end
    @(posedge clk); #1; cyc++;
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_release");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; next_free = 0; rr_last_if = 1'b1;
    if_pv = 1'b0; d_pv = 1'b0; burst_mode = 1'b0; b2b_mode = 1'b0;
    obs_if_g_burst = 0; streak = 0; max_streak = 0;
    exp_if_rdata = '0; exp_d_rdata = '0;
    for (int k = 0; k < LAT; k++) pipe[k] = '0;
    rd_now = '0;

    // Reset with requests present: grants stay low
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_wdata = '0; d_wstrb = '0;
    #2;
    chk("rst_gate_gnt", {62'd0, if_gnt, d_gnt}, 64'(0));
    chk("rst_gate_en", 64'(mem_en), 64'(0));
    do_reset(2);

    // Single fetch
    pf(32'h10, 0);
    drain(50);

    // Conflicts: load vs fetch twice
    pf(32'h100, 0); pd(1'b0, 32'h200, '0, '0, 0);
    drain(50);
    pf(32'h104, 0); pd(1'b0, 32'h204, '0, '0, 0);
    drain(50);

    // Partial store and readback
    pd(1'b1, 32'h300, 32'h0, 4'hF, 0);
    pd(1'b1, 32'h300, 32'hDEAD_BEEF, 4'b0011, 0);
    pd(1'b0, 32'h300, '0, '0, 0);
    drain(80);
    chk("store_readback", 64'(d_rdata), 64'(32'h0000_BEEF));

    // Back-to-back queued fetches
    gcyc.delete(); b2b_mode = 1'b1;
    for (int i = 0; i < 4; i++) pf(32'h20 + 32'(4*i), 0);
    drain(80);
    b2b_mode = 1'b0;
    chk("b2b_count", 64'(gcyc.size()), 64'(4));
    for (int i = 1; i < gcyc.size(); i++)
      chk("b2b_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'(LAT));

    // Reset one cycle after a data grant
    pd(1'b0, 32'h400, '0, '0, 0);
    step();
    @(posedge clk); #1; cyc++;
    do_reset(LAT + 2);
    pd(1'b0, 32'h404, '0, '0, 0);
    drain(50);

    // Sustained data traffic with a waiting fetch
    burst_mode = 1'b1; obs_if_g_burst = 0; streak = 0; max_streak = 0;
    for (int i = 0; i < 10; i++) pd(1'b0, 32'h500 + 32'(4*i), '0, '0, 0);
    for (int i = 0; i < 12; i++) pf(32'h600 + 32'(4*i), 0);
    drain(400);
    burst_mode = 1'b0;
`ifdef ARB_RR_EN
    chk("rr_max_d_streak_ok", 64'(max_streak <= 1), 64'(1));
`else
    chk("fixed_no_if_during_burst", 64'(obs_if_g_burst), 64'(0));
`endif

    // Random mixed traffic over a small address window
    for (int i = 0; i < 40; i++) begin
      pf(32'h1000 + 32'(4 * $urandom_range(0, 15)), $urandom_range(0, 3));
      pd(1'($urandom), 32'h1000 + 32'(4 * $urandom_range(0, 15)), $urandom,
         4'($urandom), $urandom_range(0, 3));
    end
    drain(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
